// File: rtl/taglist_seq_player.sv
// Plays ROM address ranges described by taglist RAM entries, one sequence per request.
// Optional macro TAGLIST_AUTO_ADVANCE_EN chains sequences until an entry with eof set.
module taglist_seq_player #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned SEQ_W  = 7
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              gen_done,
    input  logic              play_req,
    input  logic [SEQ_W-1:0]  play_seq,
    output logic              play_busy,
    output logic [SEQ_W-1:0]  tag_rd_addr,
    input  logic [31:0]       tag_rd_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_valid,
    input  logic              rom_ready,
    output logic              seq_done,
    output logic              seq_last,
    output logic              seq_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_STREAM, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [SEQ_W-1:0]  cur_seq;
    logic [ADDR_W-1:0] cnt, end_r;
    logic              eof_r;

    logic [SEQ_W-1:0]  entry_seq;
    logic [ADDR_W-1:0] entry_start, entry_end;
    logic              entry_ok;
    logic              unused_tag_bits;

    assign entry_seq       = SEQ_W'(tag_rd_data[27:21]);
    assign entry_start     = ADDR_W'(tag_rd_data[20:11]);
    assign entry_end       = ADDR_W'(tag_rd_data[10:1]);
    assign entry_ok        = (entry_seq == cur_seq) && (entry_start <= entry_end);
    assign unused_tag_bits = ^tag_rd_data[31:28];

    always_ff @(posedge clk_50MHz) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (play_req && gen_done) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_CHECK;
            S_CHECK:  state_nxt = entry_ok ? S_STREAM : S_ERR;
            S_STREAM: if (rom_ready && (cnt == end_r)) state_nxt = S_DONE;
`ifdef TAGLIST_AUTO_ADVANCE_EN
            S_DONE:   state_nxt = eof_r ? S_IDLE : S_FETCH;
`else
            S_DONE:   state_nxt = S_IDLE;
`endif
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            cur_seq  <= '0;
            cnt      <= '0;
            end_r    <= '0;
            eof_r    <= 1'b0;
            seq_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (play_req && gen_done) cur_seq <= play_seq;
                S_CHECK:  if (entry_ok) begin
                    cnt   <= entry_start;
                    end_r <= entry_end;
                    eof_r <= tag_rd_data[0];
                end
                // cnt holds at end_r on the final beat so rom_addr never runs past the range
                S_STREAM: if (rom_ready && (cnt != end_r)) cnt <= cnt + ADDR_W'(1);
                S_DONE: begin
                    seq_last <= eof_r;
`ifdef TAGLIST_AUTO_ADVANCE_EN
                    if (!eof_r) cur_seq <= cur_seq + SEQ_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign play_busy   = (state != S_IDLE);
    assign tag_rd_addr = cur_seq;
    assign rom_addr    = cnt;
    assign rom_valid   = (state == S_STREAM);
    assign seq_done    = (state == S_DONE);
    assign seq_err     = (state == S_ERR);

endmodule

// File: tb/tb_taglist_seq_player.sv
// Randomized self-checking bench for taglist_seq_player against a range-list reference model.
module tb_taglist_seq_player;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned SEQ_W  = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              gen_done = 1'b0;
    logic              play_req = 1'b0;
    logic [SEQ_W-1:0]  play_seq = '0;
    logic              play_busy;
    logic [SEQ_W-1:0]  tag_rd_addr;
    logic [31:0]       tag_rd_data = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_valid;
    logic              rom_ready = 1'b0;
    logic              seq_done;
    logic              seq_last;
    logic              seq_err;

    taglist_seq_player #(.ADDR_W(ADDR_W), .SEQ_W(SEQ_W)) dut (
        .clk_50MHz(clk), .reset(reset), .gen_done(gen_done), .play_req(play_req),
        .play_seq(play_seq), .play_busy(play_busy), .tag_rd_addr(tag_rd_addr),
        .tag_rd_data(tag_rd_data), .rom_addr(rom_addr), .rom_valid(rom_valid),
        .rom_ready(rom_ready), .seq_done(seq_done), .seq_last(seq_last), .seq_err(seq_err)
    );

    always #10 clk = ~clk;

    logic [31:0] mem [0:127];
    always @(posedge clk) tag_rd_data <= mem[tag_rd_addr];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: observed beats and pulse counts, sampled mid-cycle
    int unsigned obs_beats[$];
    int unsigned obs_cyc[$];
    int unsigned n_done, n_err, n_valid, cyc = 0;
    logic        hold_pending = 1'b0;
    int unsigned hold_addr;

    always @(negedge clk) begin
        cyc++;
        if (reset) hold_pending = 1'b0;
        else begin
            if (hold_pending) begin
                check("hold_valid", rom_valid, 1);
                check("hold_addr", rom_addr, hold_addr);
            end
            if (rom_valid && rom_ready) begin
                obs_beats.push_back(rom_addr);
                obs_cyc.push_back(cyc);
            end
            if (rom_valid) n_valid++;
            if (seq_done)  n_done++;
            if (seq_err)   n_err++;
            hold_pending = rom_valid && !rom_ready;
            hold_addr    = rom_addr;
        end
    end

    int unsigned ready_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       rom_ready = 1'b1;
            1:       rom_ready = ~rom_ready;
            default: rom_ready = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    // Reference model: expected beats and outcome of one accepted request
    int unsigned exp_beats[$];
    int unsigned exp_done, exp_err;
    logic        exp_last = 1'b0;

    task automatic build_expect(input int unsigned s);
        int unsigned cur, es, st, en, guard;
        logic [31:0] e;
        cur = s;
        guard = 0;
        exp_beats.delete();
        exp_done = 0;
        exp_err = 0;
        while (guard < 300) begin
            e  = mem[cur];
            es = {25'd0, e[27:21]};
            st = {22'd0, e[20:11]};
            en = {22'd0, e[10:1]};
            if (es != cur || st > en) begin
                exp_err++;
                break;
            end
            for (int unsigned a = st; a <= en; a++) exp_beats.push_back(a);
            exp_done++;
            exp_last = e[0];
`ifdef TAGLIST_AUTO_ADVANCE_EN
            if (e[0]) break;
            cur = (cur + 1) % 128;
            guard++;
`else
            break;
`endif
        end
    endtask

    task automatic run_play(input int unsigned s, input int unsigned mode, input logic gd);
        int unsigned n;
        obs_beats.delete();
        obs_cyc.delete();
        n_done = 0; n_err = 0; n_valid = 0;
        ready_mode = mode;
        exp_beats.delete(); exp_done = 0; exp_err = 0;
        if (gd) build_expect(s);
        gen_done = gd;
        play_seq = s[SEQ_W-1:0];
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        if (!gd) check("busy_ignored", play_busy, 0);
        n = 0;
        while (play_busy && n < 3000) begin
            if (n == 2) begin
                play_req = 1'b1;
                play_seq = ~s[SEQ_W-1:0];
            end
            step();
            play_req = 1'b0;
            n++;
        end
        check("timeout", (n >= 3000) ? 1 : 0, 0);
        check("nbeats", obs_beats.size(), exp_beats.size());
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++)
            check("beat", obs_beats[i], exp_beats[i]);
        check("done_cnt", n_done, exp_done);
        check("err_cnt", n_err, exp_err);
        check("seq_last", seq_last, exp_last);
        check("idle_valid", rom_valid, 0);
    endtask

    function automatic logic [31:0] entry(input int unsigned sq, input int unsigned st,
                                          input int unsigned en, input logic eof);
        logic [6:0] sq7;
        logic [9:0] st10, en10;
        sq7 = sq[6:0]; st10 = st[9:0]; en10 = en[9:0];
        return {4'b0000, sq7, st10, en10, eof};
    endfunction

    initial begin
        int unsigned n, st, len, tmp, sqf;
        for (int i = 0; i < 128; i++) mem[i] = '0;

        // Reset values
        repeat (3) step();
        check("rst_busy", play_busy, 0);
        check("rst_valid", rom_valid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_tag_addr", tag_rd_addr, 0);
        check("rst_done", seq_done, 0);
        check("rst_last", seq_last, 0);
        check("rst_err", seq_err, 0);
        reset = 1'b0;
        step();

        // Request ignored while generation incomplete
        n_valid = 0;
        gen_done = 1'b0; play_seq = 7'd3; play_req = 1'b1;
        step();
        play_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("nogen_busy", play_busy, 0);
            check("nogen_tag_addr", tag_rd_addr, 0);
            step();
        end
        check("nogen_valid", n_valid, 0);

        // Four-beat sequence with consumer always ready
        mem[2] = entry(2, 10, 13, 1'b0);
        mem[3] = entry(0, 0, 0, 1'b0);
        run_play(2, 0, 1'b1);
        for (int i = 0; i < 4 && i < obs_beats.size(); i++) begin
            check("seq2_addr", obs_beats[i], 10 + i);
            check("seq2_consec", obs_cyc[i] - obs_cyc[0], i);
        end
        check("seq2_last", seq_last, 0);

        // Single beat with toggling ready
        mem[20] = entry(20, 40, 40, 1'b1);
        rom_ready = 1'b0;
        run_play(20, 1, 1'b1);
        check("single_nbeats", obs_beats.size(), 1);
        if (obs_beats.size() > 0) check("single_addr", obs_beats[0], 40);
        check("single_done", n_done, 1);

        // Mismatched sequence field
        mem[6] = entry(5, 1, 2, 1'b0);
        run_play(6, 0, 1'b1);
        check("err_pulse", n_err, 1);
        check("err_no_valid", n_valid, 0);

        // Reset mid-stream
        ready_mode = 0;
        gen_done = 1'b1; play_seq = 7'd2; play_req = 1'b1;
        step();
        play_req = 1'b0;
        n = 0;
        while (!(rom_valid && rom_addr == 10'd12) && n < 50) begin
            step();
            n++;
        end
        check("midrst_reach12", (n < 50) ? 1 : 0, 1);
        reset = 1'b1;
        step();
        check("midrst_valid", rom_valid, 0);
        check("midrst_busy", play_busy, 0);
        reset = 1'b0;
        exp_last = 1'b0;
        step();
        run_play(2, 0, 1'b1);
        if (obs_beats.size() > 0) check("restart_addr", obs_beats[0], 10);

`ifdef TAGLIST_AUTO_ADVANCE_EN
        mem[0] = entry(0, 0, 1, 1'b0);
        mem[1] = entry(1, 2, 3, 1'b1);
        run_play(0, 0, 1'b1);
        check("auto_nbeats", obs_beats.size(), 4);
        check("auto_done", n_done, 2);
        check("auto_last", seq_last, 1);
`endif

        // Randomized table and requests
        for (int unsigned i = 0; i < 128; i++) begin
            st  = $urandom_range(0, 1015);
            len = $urandom_range(0, 7);
            sqf = ($urandom_range(0, 7) == 0) ? (i ^ 1) : i;
            mem[i] = entry(sqf, st, st + len, (i % 8 == 7) ? 1'b1 : ($urandom_range(0, 1) == 1));
            if (len > 0 && $urandom_range(0, 9) == 0) begin
                tmp = st + len;
                mem[i] = entry(sqf, tmp, st, mem[i][0]);
            end
            mem[i][31:28] = 4'($urandom_range(0, 15));
        end
        for (int k = 0; k < 40; k++)
            run_play($urandom_range(0, 127), $urandom_range(0, 2), ($urandom_range(0, 4) != 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/taglist_seq_player.md
TAGLIST_SEQ_PLAYER -- requirements
Module: taglist_seq_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-002 SHALL have parameter SEQ_W, default 7, sequence number width and taglist RAM address width.
REQ-003 SHALL have port clk_50MHz  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gen_done  input  1  taglist generation complete; level.
REQ-006 SHALL have port play_req  input  1  single-cycle playback request.
REQ-007 SHALL have port play_seq  input  SEQ_W  requested sequence number.
REQ-008 SHALL have port play_busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port tag_rd_addr  output  SEQ_W  taglist RAM read address.
REQ-010 SHALL have port tag_rd_data  input  32  taglist RAM data, valid one cycle after tag_rd_addr; layout [27:21] seq, [20:11] start, [10:1] end, [0] eof.
REQ-011 SHALL have port rom_addr  output  ADDR_W  ROM address to consumer.
REQ-012 SHALL have port rom_valid  output  1  rom_addr valid.
REQ-013 SHALL have port rom_ready  input  1  consumer accepts beat.
REQ-014 SHALL have port seq_done  output  1  one-cycle pulse at end of each played sequence.
REQ-015 SHALL have port seq_last  output  1  eof bit of most recently completed sequence; held until next completion.
REQ-016 SHALL have port seq_err  output  1  one-cycle pulse on rejected entry.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, CHECK, STREAM, DONE, ERR.
REQ-018 IDLE: play_req accepted only when gen_done=1; register play_seq into cur_seq, go FETCH; play_req otherwise ignored, never queued.
REQ-019 FETCH: drive tag_rd_addr=cur_seq, go WAIT; WAIT: go CHECK; tag_rd_data sampled in CHECK.
REQ-020 CHECK: if entry seq field != cur_seq or start > end, go ERR; else load cnt=start, end_r=end, eof_r=eof, go STREAM.
REQ-021 ERR: seq_err=1 for exactly one cycle, return to IDLE; seq_done and seq_last unchanged.
REQ-022 STREAM: rom_valid=1, rom_addr=cnt; rom_addr SHALL be stable while rom_valid=1 and rom_ready=0.
REQ-023 STREAM beat on rom_valid&&rom_ready: if cnt==end_r go DONE (rom_valid low next cycle), else cnt=cnt+1.
REQ-024 start==end SHALL produce exactly one beat.
REQ-025 DONE: seq_done=1 one cycle, seq_last=eof_r, go IDLE (see REQ-031).
REQ-026 play_req while play_busy=1 SHALL be ignored.
REQ-027 No consumer timeout: STREAM waits indefinitely for rom_ready.

Reset
REQ-028 reset SHALL override all state from any state, including mid-STREAM: next cycle state=IDLE, rom_valid=0.
REQ-029 Reset values: play_busy=0, tag_rd_addr=0, rom_addr=0, rom_valid=0, seq_done=0, seq_last=0, seq_err=0, cur_seq=0.

Configuration
REQ-030 Macro TAGLIST_AUTO_ADVANCE_EN SHALL select continuous playback.
REQ-031 Defined: in DONE with eof_r=0, cur_seq=cur_seq+1 (wraps 127->0), go FETCH; eof_r=1 goes IDLE; seq_done pulses per sequence.
REQ-032 Undefined: DONE always goes IDLE; one sequence per play_req.

Verification
REQ-033 gen_done=0, play_req seq 3 -> no state change, play_busy stays 0, no RAM read.
REQ-034 Entry seq=2, start=10, end=13, eof=0, rom_ready=1 -> rom_addr 10,11,12,13 on consecutive cycles, then seq_done pulse, seq_last=0.
REQ-035 Entry start=end=40, rom_ready toggling 0/1 -> single beat addr 40 held until ready, one seq_done.
REQ-036 Entry seq field 5 at address 6, play_req seq 6 -> seq_err one cycle, no rom_valid.
REQ-037 reset asserted mid-STREAM at rom_addr 12 -> next cycle rom_valid=0, play_busy=0; new play_req seq 2 restarts at 10.
REQ-038 With TAGLIST_AUTO_ADVANCE_EN: seq 0 (0..1, eof=0), seq 1 (2..3, eof=1) -> addrs 0,1,2,3, two seq_done pulses, seq_last=1, IDLE.
